seven_segment_frame_monitor: RTL and testbench

Parametrised successor to the fixed 4-channel, 8-digit seven-segment frame interface. It captures parity-tagged frames from up to CHANNELS sources, tagged per frame, and keeps a per-channel history plus frame and error counters. It drives a hex digit bus for the selected channel in one of four display modes, with per-digit blanking and parity-error dots. It sits between the serial frame receiver and the seven-segment scan driver.

---
 rtl/seven_segment_pkg.sv | 27 ++
 rtl/seven_segment_frame_monitor_if.sv | 13 +
 rtl/seven_segment_channel_store.sv | 62 ++++++
 rtl/seven_segment_frame_monitor.sv | 151 +++++++++++++++
 tb/tb_seven_segment_frame_monitor.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment frame monitor: display mode
// codes, the blank-digit value, the history-slot record and a width helper.
package seven_segment_pkg;

    localparam logic [1:0] MODE_HIST = 2'd0;
    localparam logic [1:0] MODE_FCNT = 2'd1;
    localparam logic [1:0] MODE_ECNT = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    localparam logic [3:0] BLANK_DIGIT = 4'h0;

    // Widest payload a history slot can carry; DATA_W must not exceed it.
    // Narrower payloads are stored zero-extended.
    localparam int SLOT_PAYLOAD_W = 32;

    typedef struct packed {
        logic [SLOT_PAYLOAD_W-1:0] payload;
        logic                      err;
        logic                      valid;
    } hist_slot_t;

    // Width of a channel-select field; at least one bit even for one channel.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_segment_frame_monitor_if.sv
// Frame input bus from the serial frame receiver: strobe, parity-tagged
// frame and the source channel tag.
interface seven_segment_frame_monitor_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
);
    logic              frame_valid;
    logic [DATA_W:0]   frame;
    logic [CH_W-1:0]   frame_ch;

    modport master (output frame_valid, frame, frame_ch);
    modport slave  (input  frame_valid, frame, frame_ch);
endinterface

// File: rtl/seven_segment_channel_store.sv
// One channel's frame history (newest in slot 0), frame counter and
// parity-error counter. Clear takes priority over a simultaneous push.
module seven_segment_channel_store
    import seven_segment_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int HIST   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    err,
    input  logic                    clr,
    input  logic [DATA_W-1:0]       payload,
    output hist_slot_t [HIST-1:0]   hist,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    hist_slot_t [HIST-1:0] hist_reg;
    logic [CNT_W-1:0]      frame_cnt_reg;
    logic [CNT_W-1:0]      err_cnt_reg;
    hist_slot_t            new_slot;

    // Build the slot record for an incoming frame.
    always_comb begin
        new_slot         = '0;
        new_slot.payload = SLOT_PAYLOAD_W'(payload);
        new_slot.err     = err;
        new_slot.valid   = 1'b1;
    end

    // History shift register and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg      <= '0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (clr) begin
            hist_reg      <= '0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (push) begin
            for (int k = HIST - 1; k > 0; k--) begin
                hist_reg[k] <= hist_reg[k-1];
            end
            hist_reg[0] <= new_slot;
            if (frame_cnt_reg != '1) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (err && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign hist      = hist_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: rtl/seven_segment_frame_monitor.sv
// Seven-segment frame monitor: checks frame parity, routes accepted frames
// to per-channel stores and drives a registered hex-digit display of the
// selected channel in history / frame-count / error-count / blank mode.
module seven_segment_frame_monitor
    import seven_segment_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DIGITS     = 8,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    seven_segment_frame_monitor_if.slave      frame_bus,
    input  logic [sel_width(CHANNELS)-1:0]    channel,
    input  logic [1:0]                        mode,
    input  logic                              freeze,
    input  logic                              clear,
    output logic [DIGITS*4-1:0]               digit,
    output logic [DIGITS-1:0]                 digit_en,
    output logic [DIGITS-1:0]                 en_dot,
    output logic                              parity_err
);

    localparam int NPD  = DATA_W / 4;      // digits per history slot
    localparam int HIST = DIGITS / NPD;    // history slots per channel
    localparam int DW   = DIGITS * 4;
    localparam logic [DIGITS-1:0] CNT_DIGIT_MASK =
        {DIGITS{1'b1}} >> (DIGITS - CNT_W / 4);

    logic                  parity_bad;
    logic                  accept;
    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   clr;

    hist_slot_t [HIST-1:0] hist_all      [CHANNELS];
    logic [CNT_W-1:0]      frame_cnt_all [CHANNELS];
    logic [CNT_W-1:0]      err_cnt_all   [CHANNELS];

    hist_slot_t [HIST-1:0] sel_hist;
    logic [CNT_W-1:0]      sel_fcnt;
    logic [CNT_W-1:0]      sel_ecnt;
    logic                  sel_valid;

    logic [DW-1:0]         digit_next;
    logic [DIGITS-1:0]     digit_en_next;
    logic [DIGITS-1:0]     en_dot_next;

    logic [DW-1:0]         digit_reg;
    logic [DIGITS-1:0]     digit_en_reg;
    logic [DIGITS-1:0]     en_dot_reg;
    logic                  parity_err_reg;

    assign parity_bad = (^frame_bus.frame) != 1'(PARITY_ODD);
    assign accept     = frame_bus.frame_valid && (int'(frame_bus.frame_ch) < CHANNELS);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign push[gi] = accept && (int'(frame_bus.frame_ch) == gi);
            assign clr[gi]  = clear && (int'(channel) == gi);

            seven_segment_channel_store #(
                .DATA_W (DATA_W),
                .HIST   (HIST),
                .CNT_W  (CNT_W)
            ) u_store (
                .clk       (clk),
                .rst       (rst),
                .push      (push[gi]),
                .err       (parity_bad),
                .clr       (clr[gi]),
                .payload   (frame_bus.frame[DATA_W-1:0]),
                .hist      (hist_all[gi]),
                .frame_cnt (frame_cnt_all[gi]),
                .err_cnt   (err_cnt_all[gi])
            );
        end
    endgenerate

    // Select the displayed channel's state; an out-of-range channel shows blank.
    always_comb begin
        sel_hist  = hist_all[0];
        sel_fcnt  = frame_cnt_all[0];
        sel_ecnt  = err_cnt_all[0];
        sel_valid = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(channel) == c) begin
                sel_hist  = hist_all[c];
                sel_fcnt  = frame_cnt_all[c];
                sel_ecnt  = err_cnt_all[c];
                sel_valid = 1'b1;
            end
        end
    end

    // Format the next display image according to the display mode.
    always_comb begin
        digit_next    = {DIGITS{BLANK_DIGIT}};
        digit_en_next = '0;
        en_dot_next   = '0;
        if (sel_valid) begin
            case (mode)
                MODE_HIST: begin
                    for (int k = 0; k < HIST; k++) begin
                        if (sel_hist[k].valid) begin
                            digit_next = digit_next | (DW'(sel_hist[k].payload) << (k * DATA_W));
                            digit_en_next[k*NPD +: NPD] = '1;
                            en_dot_next[k*NPD]          = sel_hist[k].err;
                        end
                    end
                end
                MODE_FCNT: begin
                    digit_next    = DW'(sel_fcnt);
                    digit_en_next = CNT_DIGIT_MASK;
                end
                MODE_ECNT: begin
                    digit_next    = DW'(sel_ecnt);
                    digit_en_next = CNT_DIGIT_MASK;
                end
                default: begin
                    digit_next    = {DIGITS{BLANK_DIGIT}};
                    digit_en_next = '0;
                end
            endcase
        end
    end

    // Output registers: display reloads unless frozen; parity pulse always runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_reg      <= '0;
            digit_en_reg   <= '0;
            en_dot_reg     <= '0;
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= accept && parity_bad;
            if (!freeze) begin
                digit_reg    <= digit_next;
                digit_en_reg <= digit_en_next;
                en_dot_reg   <= en_dot_next;
            end
        end
    end

    assign digit      = digit_reg;
    assign digit_en   = digit_en_reg;
    assign en_dot     = en_dot_reg;
    assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_seven_segment_frame_monitor.sv
// Testbench for seven_segment_frame_monitor (default parameters): directed
// frames with literal expectations, plus a queue-style reference model that
// is compared against the outputs on every falling clock edge.
module tb_seven_segment_frame_monitor;

    localparam int CHANNELS = 4;
    localparam int DIGITS   = 8;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 16;
    localparam int HIST     = 4;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH_W-1:0]   channel = '0;
    logic [1:0]        mode = 2'd0;
    logic              freeze = 1'b0;
    logic              clear = 1'b0;
    logic [31:0]       digit;
    logic [7:0]        digit_en;
    logic [7:0]        en_dot;
    logic              parity_err;

    seven_segment_frame_monitor_if #(.DATA_W(DATA_W), .CH_W(CH_W)) frame_bus ();

    seven_segment_frame_monitor #(
        .CHANNELS   (CHANNELS),
        .DIGITS     (DIGITS),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_bus  (frame_bus),
        .channel    (channel),
        .mode       (mode),
        .freeze     (freeze),
        .clear      (clear),
        .digit      (digit),
        .digit_en   (digit_en),
        .en_dot     (en_dot),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel list of {err,payload} (index 0 newest),
    // its length, and the two counters; display expectation is the picture
    // of the selected channel as it stood before the latest edge.
    logic [8:0]  m_hist [CHANNELS][HIST];
    int          m_n    [CHANNELS];
    int          m_fcnt [CHANNELS];
    int          m_ecnt [CHANNELS];
    logic [31:0] exp_digit;
    logic [7:0]  exp_en;
    logic [7:0]  exp_dot;
    logic        exp_perr;

    task automatic view(input int ch, input int md,
                        output logic [31:0] d, output logic [7:0] e, output logic [7:0] p);
        d = '0; e = '0; p = '0;
        if (md == 0) begin
            for (int k = 0; k < m_n[ch]; k++) begin
                d[k*8 +: 8] = m_hist[ch][k][7:0];
                e[k*2 +: 2] = 2'b11;
                p[k*2]      = m_hist[ch][k][8];
            end
        end else if (md == 1) begin
            d = 32'(m_fcnt[ch]);
            e = 8'h0F;
        end else if (md == 2) begin
            d = 32'(m_ecnt[ch]);
            e = 8'h0F;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_n[c] = 0; m_fcnt[c] = 0; m_ecnt[c] = 0;
            for (int k = 0; k < HIST; k++) m_hist[c][k] = '0;
        end
        exp_digit = '0; exp_en = '0; exp_dot = '0; exp_perr = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                int  c;
                logic bad;
                if (!freeze) view(int'(channel), int'(mode), exp_digit, exp_en, exp_dot);
                bad = ^frame_bus.frame;
                exp_perr = frame_bus.frame_valid && bad;
                if (clear) begin
                    m_n[channel] = 0; m_fcnt[channel] = 0; m_ecnt[channel] = 0;
                end
                if (frame_bus.frame_valid && !(clear && frame_bus.frame_ch == channel)) begin
                    c = int'(frame_bus.frame_ch);
                    for (int k = HIST - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                    m_hist[c][0] = {bad, frame_bus.frame[7:0]};
                    if (m_n[c] < HIST) m_n[c]++;
                    if (m_fcnt[c] < 65535) m_fcnt[c]++;
                    if (bad && m_ecnt[c] < 65535) m_ecnt[c]++;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_digit", digit, exp_digit);
            check("cyc_digit_en", 32'(digit_en), 32'(exp_en));
            check("cyc_en_dot", 32'(en_dot), 32'(exp_dot));
            check("cyc_parity_err", 32'(parity_err), 32'(exp_perr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] f, input logic [CH_W-1:0] ch);
        frame_bus.frame_valid = 1'b1;
        frame_bus.frame       = f;
        frame_bus.frame_ch    = ch;
        tick();
        frame_bus.frame_valid = 1'b0;
        $display("frame %h on ch%0d: parity_err=%0b", f, ch, parity_err);
    endtask

    logic [8:0] ch1_frames [5];

    initial begin
        frame_bus.frame_valid = 1'b0;
        frame_bus.frame       = '0;
        frame_bus.frame_ch    = '0;
        ch1_frames = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};

        // 1: reset held with random inputs
        #1 rst = 1'b0;
        repeat (10) begin
            tick();
            frame_bus.frame_valid = 1'($urandom_range(0, 1));
            frame_bus.frame       = 9'($urandom);
            frame_bus.frame_ch    = 2'($urandom);
            channel = 2'($urandom);
            mode    = 2'($urandom);
            clear   = 1'($urandom_range(0, 1));
            freeze  = 1'($urandom_range(0, 1));
        end
        check("rst_digit", digit, 32'h0);
        check("rst_digit_en", 32'(digit_en), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        frame_bus.frame_valid = 1'b0;
        channel = '0; mode = 2'd0; clear = 1'b0; freeze = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 2: good frame on ch0
        send(9'h099, 2'd0);
        check("s2_perr", 32'(parity_err), 32'h0);
        tick();
        check("s2_digit", digit, 32'h0000_0099);
        check("s2_digit_en", 32'(digit_en), 32'h03);
        check("s2_en_dot", 32'(en_dot), 32'h00);

        // 3: bad parity frame on ch0
        send(9'h199, 2'd0);
        check("s3_perr_pulse", 32'(parity_err), 32'h1);
        tick();
        check("s3_perr_end", 32'(parity_err), 32'h0);
        check("s3_digit", digit, 32'h0000_9999);
        check("s3_digit_en", 32'(digit_en), 32'h0F);
        check("s3_en_dot", 32'(en_dot), 32'h01);
        mode = 2'd2;
        tick();
        check("s3_ecnt", digit, 32'h0000_0001);
        check("s3_ecnt_en", 32'(digit_en), 32'h0F);

        // 4: five frames on ch1 overflow a four-slot history
        channel = 2'd1; mode = 2'd0;
        foreach (ch1_frames[i]) send(ch1_frames[i], 2'd1);
        tick();
        check("s4_digit", digit, 32'h2233_4455);
        check("s4_digit_en", 32'(digit_en), 32'hFF);
        check("s4_en_dot", 32'(en_dot), 32'h00);
        mode = 2'd1;
        tick();
        check("s4_fcnt", digit, 32'h0000_0005);

        // 5: other-channel frame, then clear colliding with a frame on ch0
        channel = 2'd0; mode = 2'd0;
        tick();
        send(9'h011, 2'd2);
        tick();
        check("s5_unchanged", digit, 32'h0000_9999);
        clear = 1'b1;
        send(9'h1AA, 2'd0);
        clear = 1'b0;
        check("s5_perr", 32'(parity_err), 32'h1);
        tick();
        check("s5_hist_empty", 32'(digit_en), 32'h00);
        check("s5_hist_digit", digit, 32'h0);
        mode = 2'd1;
        tick();
        check("s5_fcnt_zero", digit, 32'h0);
        channel = 2'd1;
        tick();
        check("s5_ch1_kept", digit, 32'h0000_0005);

        // 6: freeze holds the display while storage keeps updating
        channel = 2'd0; mode = 2'd0;
        tick();
        freeze = 1'b1;
        send(9'h0FF, 2'd0);
        tick();
        check("s6_frozen", digit, 32'h0);
        check("s6_frozen_en", 32'(digit_en), 32'h00);
        freeze = 1'b0;
        tick();
        check("s6_thawed", digit, 32'h0000_00FF);
        check("s6_thawed_en", 32'(digit_en), 32'h03);

        // 7: mode 3 blanks, then asynchronous reset mid-operation
        mode = 2'd3;
        tick();
        check("s7_blank_en", 32'(digit_en), 32'h00);
        channel = 2'd1; mode = 2'd0;
        tick();
        frame_bus.frame_valid = 1'b1;
        frame_bus.frame       = 9'h066;
        frame_bus.frame_ch    = 2'd1;
        #2 rst = 1'b0;
        #1;
        check("s7_rst_digit", digit, 32'h0);
        check("s7_rst_en", 32'(digit_en), 32'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        frame_bus.frame_valid = 1'b0;
        tick();
        check("s7_hist_lost", 32'(digit_en), 32'h00);
        mode = 2'd1;
        tick();
        check("s7_cnt_lost", digit, 32'h0);
        check("s7_cnt_en", 32'(digit_en), 32'h0F);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
